// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter for a shared combinational ALU: holds operands stable for a
// settle window, captures result/flags and returns them on one tagged response channel.
module alu_issue_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_inst,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_inst,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  output logic [31:0]      alu_inst,
  output logic [31:0]      alu_reg_a,
  output logic [31:0]      alu_reg_b,
  input  logic [31:0]      alu_result,
  input  logic [2:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_result,
  output logic [2:0]       rsp_flags,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic             rr_ptr_q;
  logic             gnt_id_q;
  logic [31:0]      hold_inst_q, hold_a_q, hold_b_q;
  logic             rsp_valid_q, rsp_id_q;
  logic [31:0]      rsp_result_q;
  logic [2:0]       rsp_flags_q;
  logic [CNT_W-1:0] op_count_q;

  logic        gnt_any, gnt_sel;
  logic [31:0] sel_inst, sel_a, sel_b;

  // Under contention the requester that did not win last time is served.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) gnt_sel = ~rr_ptr_q;
    else                          gnt_sel = req1_valid;
    sel_inst = gnt_sel ? req1_inst : req0_inst;
    sel_a    = gnt_sel ? req1_a    : req0_a;
    sel_b    = gnt_sel ? req1_b    : req0_b;
  end

  // Gated by rst_n so no ready is seen while reset is held.
  assign req0_ready = rst_n && (state_q == StIdle) && gnt_any && !gnt_sel;
  assign req1_ready = rst_n && (state_q == StIdle) && gnt_any &&  gnt_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      rr_ptr_q     <= 1'b1;
      gnt_id_q     <= 1'b0;
      hold_inst_q  <= '0;
      hold_a_q     <= '0;
      hold_b_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      op_count_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt_any) begin
            hold_inst_q <= sel_inst;
            hold_a_q    <= sel_a;
            hold_b_q    <= sel_b;
            gnt_id_q    <= gnt_sel;
            cnt_q       <= 4'(SETTLE_CYCLES - 1);
            state_q     <= StSettle;
          end
        end
        StSettle: begin
          if (cnt_q == 4'd0) begin
            rsp_result_q <= alu_result;
            rsp_flags_q  <= alu_flags;
            rsp_id_q     <= gnt_id_q;
            rsp_valid_q  <= 1'b1;
            state_q      <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rr_ptr_q    <= gnt_id_q;
            op_count_q  <= op_count_q + CNT_W'(1);
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign alu_inst   = hold_inst_q;
  assign alu_reg_a  = hold_a_q;
  assign alu_reg_b  = hold_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign busy       = (state_q != StIdle);
  assign op_count   = op_count_q;

endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Sequences the shared combinational MIPS-style ALU (`alu`) and shares it between two requesters, e.g. an integer pipe and a debug/host port.
- Accepts one instruction/operand bundle at a time, arbitrates round-robin, holds ALU inputs stable for a settle window, captures result and flags, and returns them on a single tagged response channel.
- Sits between the requesters and one `alu` instance; the `alu` ports are driven only by this block.

Parameters:
- SETTLE_CYCLES, 2, cycles the ALU inputs are held before capture; legal range 1..15.
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has a bundle
- req0_ready  out  1  requester 0 bundle accepted this cycle
- req0_inst  in  32  requester 0 instruction word
- req0_a  in  32  requester 0 reg_a operand
- req0_b  in  32  requester 0 reg_b operand
- req1_valid  in  1  requester 1 has a bundle
- req1_ready  out  1  requester 1 bundle accepted this cycle
- req1_inst  in  32  requester 1 instruction word
- req1_a  in  32  requester 1 reg_a operand
- req1_b  in  32  requester 1 reg_b operand
- alu_inst  out  32  to alu inst
- alu_reg_a  out  32  to alu reg_a
- alu_reg_b  out  32  to alu reg_b
- alu_result  in  32  from alu result
- alu_flags  in  3  from alu flags
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester that issued this response
- rsp_result  out  32  captured result
- rsp_flags  out  3  captured flags
- busy  out  1  high in any state except IDLE
- op_count  out  CNT_W  completed responses, wraps

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; hold registers, rsp_result, rsp_flags, rsp_id and op_count = 0.
  - rsp_valid=0, busy=0, req*_ready=0.
  - rr_ptr=1, so requester 0 wins the first contention.
- Reset asserted mid-operation aborts the operation: no response is produced and no ready is issued after reset.
- States: IDLE, SETTLE, RESP.
- IDLE:
  - req*_ready is combinational and asserted only in IDLE, for the granted requester only.
  - Grant: if only one requester is valid, grant it. If both are valid, grant the one not equal to rr_ptr.
  - On a grant, at the clock edge: latch inst/a/b into the hold registers, store gnt_id, load settle counter with SETTLE_CYCLES-1, go to SETTLE.
  - With no valid requester: stay in IDLE; hold registers keep their last value.
- alu_inst, alu_reg_a and alu_reg_b are always driven from the hold registers. They never change outside the IDLE->SETTLE edge.
- SETTLE:
  - Decrement the counter each cycle.
  - When the counter reaches 0: capture alu_result and alu_flags into rsp_result/rsp_flags, set rsp_id=gnt_id and rsp_valid=1, go to RESP.
- RESP:
  - rsp_valid, rsp_id, rsp_result and rsp_flags stay stable until rsp_valid && rsp_ready.
  - On that handshake edge: rsp_valid=0, rr_ptr=gnt_id, op_count+=1 (wraps at 2^CNT_W-1 -> 0), go to IDLE.
  - No new request is accepted in the handshake cycle.
- Latency and throughput:
  - Accept edge T -> rsp_valid high after edge T+SETTLE_CYCLES.
  - With rsp_ready held high, the minimum interval between accepts is SETTLE_CYCLES+2 cycles.
- Requester protocol: hold valid and the bundle until ready. Dropping valid while not granted is legal and has no effect.
- rsp_ready high before rsp_valid rises: the handshake completes in the first RESP cycle.
- Flags are passed through exactly as captured; no interpretation.
- Only the holding registers are wide datapath. No arithmetic is performed in this block apart from the counters.

Test Plan:
- Single issue: req0 inst=0x340000F0 (ori, rs=0), a=0x0000000F, b=0, rsp_ready=1 -> req0_ready for 1 cycle; rsp_valid 2 cycles later (SETTLE_CYCLES=2); rsp_result=0x000000FF, rsp_id=0, op_count=1.
- Contention fairness: both valid continuously, distinct bundles -> grants alternate 0,1,0,1; four responses with rsp_id 0,1,0,1; op_count=4.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> outputs stable and no req*_ready; release rsp_ready -> one handshake, IDLE next cycle.
- Input stability: change req0_a while in SETTLE/RESP -> alu_reg_a unchanged; rsp_result reflects the accepted values.
- Reset mid-op: drop rst_n during SETTLE -> rsp_valid=0 and busy=0 immediately; after release, both valid -> requester 0 granted first.
- Wrap: CNT_W=4, 16 completed ops -> op_count returns to 0.
